branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Tracks the prediction supplied to every fetched instruction from IF to MEM, and resolves branches in MEM.
//  Produces the counter-update strobe (write / br_en / index) for the 2-bit predictor array.
//  Produces the pipeline flush and redirect PC on a misprediction.
//  Sits between the fetch stage (prediction source) and the MEM stage (branch outcome).
// PARAMETERS
//  DEPTH    4   in-flight tracking entries (IF..MEM); power of 2, >=2
//  IDX_W    4   predictor index width; index = if_pc[IDX_W:1]
//  PC_W     16  PC width
// PORTS
//  clk             in   1      rising-edge clock
//  reset_n         in   1      synchronous, active-low reset
//  if_adv          in   1      fetch accepts an instruction this cycle (push)
//  if_pc           in   PC_W   PC of the fetched instruction
//  if_pred         in   1      prediction read from the predictor array for if_pc
//  mem_adv         in   1      MEM retires its instruction this cycle (pop)
//  mem_is_br       in   1      retiring instruction is a conditional branch
//  mem_br_en       in   1      actual branch outcome
//  mem_target      in   PC_W   computed branch target
//  mem_pc_plus2    in   PC_W   fall-through PC
//  fetch_stall     out  1      tracker full; fetch must hold
//  pred_write      out  1      predictor update strobe
//  pred_br_en      out  1      outcome for the predictor update
//  pred_index      out  IDX_W  index for the predictor update
//  flush           out  1      kill IF..EX and redirect fetch
//  redirect_pc     out  PC_W   fetch PC after a flush
// BEHAVIOUR
//  Reset: clear the FIFO (count=0, both pointers=0). All outputs are 0. Counters are 0.
//  Entry = {pred, index}. Push on if_adv && !fetch_stall && !flush. Pop on mem_adv && count!=0.
//  fetch_stall = (count==DEPTH) && !mem_adv. A simultaneous push and pop at full is legal; count is unchanged.
//  mem_adv with an empty FIFO is a protocol error: ignore it and drive no outputs.
//  if_adv while fetch_stall is high is dropped; the entry is not written.
//  Resolution is computed in the pop cycle N. All outputs are registered and valid in cycle N+1 only (pulse).
//  pred_write = mem_is_br. pred_br_en = mem_br_en. pred_index = head.index.
//  Mispredict = (mem_is_br && head.pred != mem_br_en) || (!mem_is_br && head.pred).
//  On mispredict: flush = 1. redirect_pc = (mem_is_br && mem_br_en) ? mem_target : mem_pc_plus2.
//  Flush cycle (N+1): FIFO cleared on the N+1 edge. Any push or pop in that cycle is discarded.
//  Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  Reset asserted mid-operation overrides everything, including a pending flush.
//  Two consecutive pops give back-to-back single-cycle update pulses, with no bubble.
// CONFIGURATION
//  BR_PERF_CTR_EN defined: adds two outputs, br_count[15:0] and mispred_count[15:0].
//   Both are 16-bit saturating counters, updated with the registered outputs (N+1).
//   Both are reset to 0.
//  BR_PERF_CTR_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  Package br_pkg: br_entry_t (packed {logic pred; logic [IDX_W-1:0] index}) and constants BR_DEPTH and BR_IDX_W.
//  Sub-module br_track_fifo: the DEPTH-entry circular buffer with push, pop, clear, full, empty and head.
//  The top level holds the resolve logic, the output registers and the optional counters.
// TESTING
//  1. Reset: hold reset_n=0 for 2 cycles with if_adv=1 -> all outputs 0, fetch_stall=0, nothing queued.
//  2. Correct NT: push pc=0x0006 with pred=0; pop with is_br=1, br_en=0 -> N+1: pred_write=1, pred_index=3, pred_br_en=0, flush=0.
//  3. Mispredict T: push pc=0x0010 with pred=0; pop with is_br=1, br_en=1, target=0x0040 -> N+1: flush=1, redirect_pc=0x0040, pred_write=1, FIFO empty at N+2.
//  4. Non-branch predicted taken: push pred=1; pop with is_br=0, pc_plus2=0x0022 -> flush=1, redirect_pc=0x0022, pred_write=0.
//  5. Full/wrap: 4 pushes with no pop -> fetch_stall=1 and a 5th push is dropped. Then push+pop in the same cycle for 8 cycles -> order preserved across pointer wrap.
//  6. BR_PERF_CTR_EN: 3 branches with 1 mispredict -> br_count=3, mispred_count=1. Preload near 0xFFFF -> counters saturate.

Source files
------------

// File: rtl/br_pkg.sv
// Package for the branch resolve unit.
// Holds the default tracker depth and predictor index width, and the
// per-instruction tracking entry {pred, index}.
package br_pkg;
  localparam int BR_DEPTH = 4;
  localparam int BR_IDX_W = 4;

  typedef struct packed {
    logic                pred;
    logic [BR_IDX_W-1:0] index;
  } br_entry_t;
endpackage

// File: rtl/br_track_fifo.sv
// Circular buffer tracking in-flight predictions from IF to MEM.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_push, i_data   : write one entry (caller guarantees space or same-cycle pop)
//   i_pop            : drop the head entry (caller guarantees non-empty)
//   i_clear          : empty the buffer; wins over push/pop
//   o_head           : oldest entry
//   o_full, o_empty  : occupancy flags
module br_track_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH,
  parameter int W     = $bits(br_entry_t)
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage carries no reset; pointers/count define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are log2(DEPTH) wide so they wrap without extra logic.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks the prediction given to each fetched
// instruction and resolves it when the instruction retires from MEM.
// Ports:
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_if_adv/i_if_pc/i_if_pred: fetch push (entry = {pred, pc[IDX_W:1]})
//   i_mem_adv/i_mem_is_br/i_mem_br_en/i_mem_target/i_mem_pc_plus2: MEM pop
//   o_fetch_stall             : tracker full and not draining this cycle
//   o_pred_write/o_pred_br_en/o_pred_index : predictor update pulse (N+1)
//   o_flush/o_redirect_pc     : mispredict flush and new fetch PC (N+1)
// Optional (macro BR_PERF_CTR_EN): o_br_count, o_mispred_count, 16-bit
// saturating counters of update pulses and flushes.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH,
  parameter int IDX_W = BR_IDX_W,
  parameter int PC_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_if_adv,
  input  logic [PC_W-1:0]  i_if_pc,
  input  logic             i_if_pred,
  input  logic             i_mem_adv,
  input  logic             i_mem_is_br,
  input  logic             i_mem_br_en,
  input  logic [PC_W-1:0]  i_mem_target,
  input  logic [PC_W-1:0]  i_mem_pc_plus2,
  output logic             o_fetch_stall,
  output logic             o_pred_write,
  output logic             o_pred_br_en,
  output logic [IDX_W-1:0] o_pred_index,
  output logic             o_flush,
  output logic [PC_W-1:0]  o_redirect_pc
`ifdef BR_PERF_CTR_EN
  ,
  output logic [15:0]      o_br_count,
  output logic [15:0]      o_mispred_count
`endif
);
  br_entry_t w_in, w_head;
  logic      w_full, w_empty, w_push, w_pop, w_mispred;
  logic      w_unused;

  // Only pc[IDX_W:1] indexes the predictor.
  assign w_unused = ^{i_if_pc[PC_W-1:IDX_W+1], i_if_pc[0]};

  assign w_in.pred  = i_if_pred;
  assign w_in.index = i_if_pc[IDX_W:1];

  assign o_fetch_stall = w_full && !i_mem_adv;

  // o_flush is high in the cycle after a mispredict: everything younger is
  // being killed, so that cycle's push/pop are dropped and the tracker clears.
  assign w_push = i_if_adv && !o_fetch_stall && !o_flush;
  assign w_pop  = i_mem_adv && !w_empty && !o_flush;

  br_track_fifo #(.DEPTH(DEPTH), .W($bits(br_entry_t))) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clear  (o_flush),
    .i_data   (w_in),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // A non-branch predicted taken also redirected fetch, so it mispredicts.
  assign w_mispred = i_mem_is_br ? (w_head.pred != i_mem_br_en) : w_head.pred;

  // Outputs are single-cycle pulses; zero whenever no valid pop happened.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pred_write  <= 1'b0;
      o_pred_br_en  <= 1'b0;
      o_pred_index  <= '0;
      o_flush       <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_pred_write  <= w_pop && i_mem_is_br;
      o_pred_br_en  <= w_pop && i_mem_br_en;
      o_pred_index  <= w_pop ? w_head.index : '0;
      o_flush       <= w_pop && w_mispred;
      if (w_pop && w_mispred)
        o_redirect_pc <= (i_mem_is_br && i_mem_br_en) ? i_mem_target : i_mem_pc_plus2;
      else
        o_redirect_pc <= '0;
    end
  end

`ifdef BR_PERF_CTR_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_br_count      <= '0;
      o_mispred_count <= '0;
    end else begin
      if (o_pred_write && (o_br_count != 16'hFFFF))
        o_br_count <= o_br_count + 16'd1;
      if (o_flush && (o_mispred_count != 16'hFFFF))
        o_mispred_count <= o_mispred_count + 16'd1;
    end
  end
`endif
endmodule
